dht_sensor_responder: RTL

//  Single-wire (DHT11-style) temperature/humidity sensor, device side. Answers a

---
 rtl/dht_sensor_responder.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/dht_sensor_responder.sv
// Single-wire DHT11-style sensor, device side: answers a host start
// pulse with the response preamble and a 40-bit humidity/temperature frame.
module dht_sensor_responder #(
  parameter int CYC_PER_US   = 100,
  parameter int START_LOW_US = 18000,
  parameter int RESP_WAIT_US = 30,
  parameter int RESP_LOW_US  = 80,
  parameter int RESP_HIGH_US = 80,
  parameter int BIT_LOW_US   = 50,
  parameter int BIT0_HIGH_US = 26,
  parameter int BIT1_HIGH_US = 70
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_in,
  output logic       io_drive_low,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       frame_done,
  output logic       abort
);

  localparam int C_START = START_LOW_US * CYC_PER_US;
  localparam int C_DLY   = RESP_WAIT_US * CYC_PER_US;
  localparam int C_RLOW  = RESP_LOW_US * CYC_PER_US;
  localparam int C_RHIGH = RESP_HIGH_US * CYC_PER_US;
  localparam int C_BLOW  = BIT_LOW_US * CYC_PER_US;
  localparam int C_B0    = BIT0_HIGH_US * CYC_PER_US;
  localparam int C_B1    = BIT1_HIGH_US * CYC_PER_US;

  localparam int M0 = (C_START > C_DLY) ? C_START : C_DLY;
  localparam int M1 = (C_RLOW > C_RHIGH) ? C_RLOW : C_RHIGH;
  localparam int M2 = (C_BLOW > C_B1) ? C_BLOW : C_B1;
  localparam int M3 = (M0 > M1) ? M0 : M1;
  localparam int C_MAX = (M3 > M2) ? M3 : M2;
  localparam int TW = $clog2(C_MAX + 1);

  localparam logic [TW-1:0] L_START = TW'(C_START);
  localparam logic [TW-1:0] L_DLY   = TW'(C_DLY);
  localparam logic [TW-1:0] L_RLOW  = TW'(C_RLOW);
  localparam logic [TW-1:0] L_RHIGH = TW'(C_RHIGH);
  localparam logic [TW-1:0] L_BLOW  = TW'(C_BLOW);
  localparam logic [TW-1:0] L_B0    = TW'(C_B0);
  localparam logic [TW-1:0] L_B1    = TW'(C_B1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START_DET = 4'd1;
  localparam logic [3:0] S_WAIT_REL  = 4'd2;
  localparam logic [3:0] S_RESP_DLY  = 4'd3;
  localparam logic [3:0] S_RESP_LOW  = 4'd4;
  localparam logic [3:0] S_RESP_HIGH = 4'd5;
  localparam logic [3:0] S_BIT_LOW   = 4'd6;
  localparam logic [3:0] S_BIT_HIGH  = 4'd7;
  localparam logic [3:0] S_END_LOW   = 4'd8;

  logic          sync1;
  logic          line_s;
  logic [3:0]    state;
  logic [3:0]    state_nx;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nx;
  logic [TW-1:0] phase_len;
  logic          phase_end;
  logic          watched;
  logic          contend;
  logic [1:0]    low_cnt;
  logic [1:0]    low_cnt_nx;
  logic [5:0]    bit_cnt;
  logic [39:0]   shreg;
  logic [7:0]    chk;
  logic          load;
  logic          shift;
  logic          done_nx;
  logic          abort_nx;
  logic          drive_nx;
  logic          busy_nx;

  assign chk = hum_int + hum_dec + temp_int + temp_dec;

  always_comb begin
    phase_len = L_START;
    unique case (state)
      S_RESP_DLY:  phase_len = L_DLY;
      S_RESP_LOW:  phase_len = L_RLOW;
      S_RESP_HIGH: phase_len = L_RHIGH;
      S_BIT_LOW:   phase_len = L_BLOW;
      S_END_LOW:   phase_len = L_BLOW;
      S_BIT_HIGH:  phase_len = shreg[39] ? L_B1 : L_B0;
      default:     phase_len = L_START;
    endcase
  end

  assign phase_end = (timer == phase_len - TW'(1));

  // Released phases are where a foreign low means contention.
  assign watched = (state == S_RESP_DLY) ||
                   (state == S_RESP_HIGH) ||
                   (state == S_BIT_HIGH);
  assign contend = watched && !line_s && (low_cnt == 2'd3);

  always_comb begin
    state_nx = state;
    timer_nx = timer + TW'(1);
    load     = 1'b0;
    shift    = 1'b0;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    unique case (state)
      S_IDLE: begin
        timer_nx = '0;
        if (!line_s) state_nx = S_START_DET;
      end
      S_START_DET: begin
        // The IDLE cycle that saw the first low counts toward the minimum.
        if (line_s) begin
          state_nx = S_IDLE;
          timer_nx = '0;
        end else if (timer == L_START - TW'(2)) begin
          state_nx = S_WAIT_REL;
          timer_nx = '0;
        end
      end
      S_WAIT_REL: begin
        timer_nx = '0;
        if (line_s) begin
          state_nx = S_RESP_DLY;
          timer_nx = TW'(1);
          load     = 1'b1;
        end
      end
      S_RESP_DLY: begin
        if (contend) begin
          state_nx = S_IDLE;
          timer_nx = '0;
          abort_nx = 1'b1;
        end else if (phase_end) begin
          state_nx = S_RESP_LOW;
          timer_nx = '0;
        end
      end
      S_RESP_LOW: begin
        if (phase_end) begin
          state_nx = S_RESP_HIGH;
          timer_nx = '0;
        end
      end
      S_RESP_HIGH: begin
        if (contend) begin
          state_nx = S_IDLE;
          timer_nx = '0;
          abort_nx = 1'b1;
        end else if (phase_end) begin
          state_nx = S_BIT_LOW;
          timer_nx = '0;
        end
      end
      S_BIT_LOW: begin
        if (phase_end) begin
          state_nx = S_BIT_HIGH;
          timer_nx = '0;
        end
      end
      S_BIT_HIGH: begin
        if (contend) begin
          state_nx = S_IDLE;
          timer_nx = '0;
          abort_nx = 1'b1;
        end else if (phase_end) begin
          shift    = 1'b1;
          timer_nx = '0;
          state_nx = (bit_cnt == 6'd39) ? S_END_LOW : S_BIT_LOW;
        end
      end
      S_END_LOW: begin
        if (phase_end) begin
          state_nx = S_IDLE;
          timer_nx = '0;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        timer_nx = '0;
      end
    endcase
  end

  always_comb begin
    low_cnt_nx = low_cnt + 2'd1;
    if (state_nx != state || line_s || !watched) low_cnt_nx = 2'd0;
  end

  assign drive_nx = (state_nx == S_RESP_LOW) ||
                    (state_nx == S_BIT_LOW) ||
                    (state_nx == S_END_LOW);
  assign busy_nx  = (state_nx != S_IDLE) && (state_nx != S_START_DET);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1        <= 1'b1;
      line_s       <= 1'b1;
      state        <= S_IDLE;
      timer        <= '0;
      low_cnt      <= 2'd0;
      bit_cnt      <= 6'd0;
      shreg        <= '0;
      io_drive_low <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      abort        <= 1'b0;
    end else begin
      sync1        <= io_in;
      line_s       <= sync1;
      state        <= state_nx;
      timer        <= timer_nx;
      low_cnt      <= low_cnt_nx;
      io_drive_low <= drive_nx;
      busy         <= busy_nx;
      frame_done   <= done_nx;
      abort        <= abort_nx;
      if (load) begin
        shreg   <= {hum_int, hum_dec, temp_int, temp_dec, chk};
        bit_cnt <= 6'd0;
      end else if (shift) begin
        shreg <= shreg << 1;
        if (bit_cnt != 6'd40) bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

endmodule
